// File: rtl/jk_pkg.sv
// Shared definitions for the JK command sequencer: command codes, sequencer
// states and the JK flip-flop next-state rule used by RTL and testbench alike.
package jk_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } seq_state_t;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        case ({j, k})
            JK_HOLD:  return q;
            JK_RESET: return 1'b0;
            JK_SET:   return 1'b1;
            default:  return ~q;
        endcase
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous show-ahead FIFO holding queued {cmd, cmd_len} entries; DEPTH must
// be a power of two so the extra pointer bit separates full from empty.
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Queues JK commands and drives J/K for cmd_len cycles plus an idle gap, while
// modelling the flip-flop output. Define JK_SEQ_READBACK_EN to check q_fb against it.
module jk_cmd_sequencer
    import jk_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int GAP   = 2,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             J,
    output logic             K,
    output logic             busy,
    output logic             done,
    output logic             q_expect,
    input  logic             q_fb,
    output logic             mismatch
);
    localparam int                GAP_W    = (GAP > 1) ? $clog2(GAP + 1) : 1;
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP);
    localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

    seq_state_t       state_q, state_d;
    logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             j_q, j_d, k_q, k_d;
    logic             q_expect_q, q_expect_d;

    logic             fifo_pop, fifo_full, fifo_empty;
    logic [LEN_W+1:0] head;
    logic [1:0]       head_cmd;
    logic [LEN_W-1:0] head_len;

    jk_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(LEN_W + 2)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_valid),
        .wdata ({cmd, cmd_len}),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_cmd = head[LEN_W+1:LEN_W];
    assign head_len = head[LEN_W-1:0];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        len_cnt_d = len_cnt_q;
        gap_cnt_d = gap_cnt_q;
        j_d       = j_q;
        k_d       = k_q;
        fifo_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                j_d = 1'b0;
                k_d = 1'b0;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    {j_d, k_d} = head_cmd;
                    len_cnt_d  = (head_len == '0) ? LEN_ONE : head_len;
                    state_d    = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                len_cnt_d = len_cnt_q - LEN_ONE;
                if (len_cnt_q == LEN_ONE) begin
                    j_d = 1'b0;
                    k_d = 1'b0;
                    if (GAP > 0) begin
                        gap_cnt_d = GAP_LOAD;
                        state_d   = ST_GAP;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q - GAP_ONE;
                if (gap_cnt_q == GAP_ONE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        q_expect_d = jk_next(q_expect_q, j_q, k_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            len_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            j_q        <= 1'b0;
            k_q        <= 1'b0;
            q_expect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_cnt_q  <= len_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            j_q        <= j_d;
            k_q        <= k_d;
            q_expect_q <= q_expect_d;
        end
    end

    assign cmd_ready = !fifo_full;
    assign J         = j_q;
    assign K         = k_q;
    assign q_expect  = q_expect_q;
    assign done      = (state_q == ST_DRIVE) && (len_cnt_q == LEN_ONE);
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;

`ifdef JK_SEQ_READBACK_EN
    logic armed_q;
    logic mismatch_q, mismatch_d;

    // The first edge after reset release is skipped so the flop downstream can settle.
    always_comb begin
        mismatch_d = mismatch_q || (armed_q && (q_fb != q_expect_q));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed_q    <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            armed_q    <= 1'b1;
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`else
    logic unused_q_fb;
    assign unused_q_fb = q_fb;
    assign mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Randomized bench for jk_cmd_sequencer: a schedule-based reference model predicts
// J/K, done, busy, cmd_ready, q_expect and mismatch for every cycle.
module tb_jk_cmd_sequencer;
    import jk_pkg::*;

    localparam int DEPTH = 4;
    localparam int GAP   = 2;
    localparam int LEN_W = 4;
    localparam int MAXC  = 4096;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd = 2'b00;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             q_fb = 1'b0;
    logic             cmd_ready, J, K, busy, done, q_expect, mismatch;

    int tests = 0;
    int fails = 0;

    jk_cmd_sequencer #(.DEPTH(DEPTH), .GAP(GAP), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .cmd_len   (cmd_len),
        .J         (J),
        .K         (K),
        .busy      (busy),
        .done      (done),
        .q_expect  (q_expect),
        .q_fb      (q_fb),
        .mismatch  (mismatch)
    );

    always #5 clk = ~clk;

    // Expected values indexed by edge number since the last reset release.
    logic [1:0] jk_m   [MAXC];
    bit         done_m [MAXC];
    bit         busy_m [MAXC];
    bit         q_m    [MAXC];
    int         occ_m  [MAXC];
    int         e;
    int         next_free;
    bit         mm_exp, mm_pend, fb_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, e, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < MAXC; i++) begin
            jk_m[i]   = 2'b00;
            done_m[i] = 1'b0;
            busy_m[i] = 1'b0;
            q_m[i]    = 1'b0;
            occ_m[i]  = 0;
        end
        e         = 0;
        next_free = 0;
        mm_exp    = 1'b0;
        mm_pend   = 1'b0;
    endtask

    // Command accepted at edge n: it starts driving at the first edge after both
    // n and the end of the previous command's drive + gap + idle slot.
    task automatic model_push(input logic [1:0] c, input logic [LEN_W-1:0] l);
        int n, le, start;
        n     = e + 1;
        le    = (l == '0) ? 1 : int'(l);
        start = (n + 1 > next_free) ? n + 1 : next_free;
        for (int i = start; i < start + le && i < MAXC; i++) jk_m[i] = c;
        if (start + le - 1 < MAXC) done_m[start + le - 1] = 1'b1;
        for (int i = n; i < start + le + GAP && i < MAXC; i++) busy_m[i] = 1'b1;
        for (int i = n; i < start && i < MAXC; i++) occ_m[i]++;
        next_free = start + le + GAP + 1;
    endtask

    task automatic check_all();
        if (e > 0) q_m[e] = jk_next(q_m[e-1], jk_m[e-1][1], jk_m[e-1][0]);
        check("J",         32'(J),         32'(jk_m[e][1]));
        check("K",         32'(K),         32'(jk_m[e][0]));
        check("done",      32'(done),      32'(done_m[e]));
        check("busy",      32'(busy),      32'(busy_m[e]));
        check("cmd_ready", 32'(cmd_ready), 32'(occ_m[e] < DEPTH));
        check("q_expect",  32'(q_expect),  32'(q_m[e]));
        check("mismatch",  32'(mismatch),  32'(mm_exp));
        q_fb = fb_bad ? ~q_m[e] : q_m[e];
`ifdef JK_SEQ_READBACK_EN
        mm_pend = (e >= 1) && (q_fb != q_m[e]);
`endif
    endtask

    task automatic step(input bit v, input logic [1:0] c, input logic [LEN_W-1:0] l,
                        output bit acc);
        cmd_valid = v;
        cmd       = c;
        cmd_len   = l;
        acc       = v && (occ_m[e] < DEPTH);
        if (acc) model_push(c, l);
        @(posedge clk);
        e++;
        mm_exp = mm_exp | mm_pend;
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, '0, acc);
    endtask

    task automatic offer(input logic [1:0] c, input logic [LEN_W-1:0] l);
        bit acc;
        int n;
        n = 0;
        do begin
            step(1'b1, c, l, acc);
            n++;
        end while (!acc && n < 200);
        check("offer_accepted", 32'(acc), 32'd1);
        cmd_valid = 1'b0;
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, releases on a falling edge.
    task automatic do_reset();
        #2;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check("rst_J",        32'(J),        32'd0);
        check("rst_K",        32'(K),        32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_q_expect", 32'(q_expect), 32'd0);
        check("rst_mismatch", 32'(mismatch), 32'd0);
        model_clear();
        fb_bad = 1'b0;
        q_fb   = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_all();
    endtask

    initial begin
        fb_bad = 1'b0;
        model_clear();
        do_reset();

        offer(JK_SET, 4'd1);
        idle(8);
        offer(JK_TOGGLE, 4'd3);
        idle(10);

        // Long HOLD stalls the sequencer while five more commands queue behind it.
        offer(JK_HOLD, 4'd15);
        offer(JK_RESET, 4'd2);
        offer(JK_SET, 4'd1);
        offer(JK_TOGGLE, 4'd4);
        offer(JK_SET, 4'd3);
        offer(JK_RESET, 4'd0);
        idle(100);

        offer(JK_RESET, 4'd0);
        idle(6);

        for (int i = 0; i < 1500; i++) begin
            bit               v, acc;
            logic [1:0]       c;
            logic [LEN_W-1:0] l;
            v = ($urandom_range(0, 9) < (((i / 300) % 2 == 1) ? 8 : 3));
            c = 2'($urandom_range(0, 3));
            l = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 15))
                                            : LEN_W'($urandom_range(0, 3));
            step(v, c, l, acc);
        end
        idle(120);

        // Reset in the middle of a long TOGGLE with another command still queued.
        offer(JK_TOGGLE, 4'd8);
        offer(JK_SET, 4'd2);
        idle(3);
        do_reset();
        idle(20);

`ifdef JK_SEQ_READBACK_EN
        offer(JK_SET, 4'd1);
        idle(4);
        fb_bad = 1'b1;
        idle(1);
        fb_bad = 1'b0;
        idle(5);
        check("mismatch_sticky", 32'(mismatch), 32'd1);
        do_reset();
        offer(JK_TOGGLE, 4'd3);
        idle(10);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/jk_cmd_sequencer.md
# jk_cmd_sequencer

Command sequencer directly upstream of the team's JK flip-flop stage: accepts HOLD/RESET/SET/TOGGLE commands over a valid/ready handshake, buffers them in a small FIFO, and drives the flip-flop's J and K inputs for a programmed number of cycles per command, followed by a fixed idle gap. It keeps a cycle-accurate model of the flip-flop output (`q_expect`). A compile-time option checks that model against the real flip-flop output.

## Interface
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- GAP, 2, idle cycles (J=K=0) inserted after each command; 0 allowed
- LEN_W, 4, width of `cmd_len`
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept (= !full)
- cmd  in  2  {J,K} pattern: 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE
- cmd_len  in  LEN_W  drive cycles; 0 treated as 1
- J  out  1  registered drive to flip-flop J
- K  out  1  registered drive to flip-flop K
- busy  out  1  FSM not IDLE or FIFO non-empty
- done  out  1  one-cycle pulse in last DRIVE cycle of a command
- q_expect  out  1  modelled flip-flop output
- q_fb  in  1  flip-flop output readback (used only with macro)
- mismatch  out  1  sticky readback error

## Operation
- Reset (reset=0, async): FIFO emptied, FSM IDLE, J=K=0, done=0, busy=0, q_expect=0, mismatch=0, counters 0. cmd_ready=1 once reset released.
- Accept on rising edge with cmd_valid && cmd_ready; {cmd, cmd_len} written to FIFO. cmd_ready is purely !full; a pop in the same cycle does not raise it.
- FSM states:
  - IDLE: FIFO non-empty → pop, load len_cnt = max(cmd_len,1), J/K ← cmd, go DRIVE. Else J=K=0.
  - DRIVE: hold J/K; len_cnt decrements each cycle. At len_cnt==1: done=1; go GAP (load gap_cnt=GAP, J=K=0) if GAP>0, else IDLE (J=K=0).
  - GAP: J=K=0, gap_cnt decrements; at 1 → IDLE.
- q_expect updates on every edge per JK rule using the currently registered J/K: 00 hold, 01 →0, 10 →1, 11 invert.
- Commands execute strictly in acceptance order; none dropped.
- Reset mid-command aborts immediately; queued commands lost.

## Timing
- Empty FIFO, IDLE, accepted at edge N: J/K valid after edge N+1 for max(cmd_len,1) cycles; cleared after edge N+1+len.
- q_expect first reflects the command after edge N+2.
- done high during final DRIVE cycle (edge N+len to N+1+len).
- Back-to-back queued commands: spacing between first-drive edges = len + GAP + 1 (IDLE costs one cycle).
- cmd_len wrap: count is unsigned LEN_W; maximum 2^LEN_W−1 cycles.

## Configuration
- Macro JK_SEQ_READBACK_EN.
- Defined: every cycle after reset release, if q_fb != q_expect then mismatch←1, sticky until reset; comparison suppressed in the first cycle after reset deassertion.
- Undefined: q_fb ignored, mismatch tied 0, no comparison logic.

## Structure
- Shared package jk_pkg: command encoding constants (JK_HOLD, JK_RESET, JK_SET, JK_TOGGLE), FSM state typedef (IDLE/DRIVE/GAP), JK next-state function used by both RTL and bench.
- One sub-module: jk_cmd_fifo (synchronous FIFO, DEPTH×(2+LEN_W), full/empty flags, async active-low reset).

## Test plan
- Reset then SET len=1, GAP=2 → J=1,K=0 for one cycle after edge N+1; q_expect=1 after edge N+2; done one pulse; busy low after GAP.
- TOGGLE len=3 from q_expect=0 → J=K=1 three cycles; q_expect 1,0,1; final 1.
- Push 5 commands with DEPTH=4 and sequencer stalled in a long DRIVE → cmd_ready=0 after 4th in FIFO; all 5 executed in order once space frees.
- cmd_len=0 RESET → exactly one drive cycle, one done pulse.
- Reset asserted mid-DRIVE of TOGGLE len=8 → J=K=0, q_expect=0, busy=0 immediately; FIFO empty.
- With JK_SEQ_READBACK_EN: force q_fb to 0 after a SET → mismatch=1 and stays 1 until reset; correct q_fb → mismatch stays 0.
